banner_rom_scroller: RTL and testbench
======================================

Name: banner_rom_scroller

Overview:
- Pixel-stream reader for wide bitmap banner ROMs. Examples are title or "game over" text rendered as 1-bit rows.
- Sits between the VGA timing generator and the pixel colour mux.
- Maps the current pixel (pix_x, pix_y) to a ROM row address and column bit, and returns a registered pixel-on flag.
- Adds frame-synchronous horizontal scrolling with wrap-around, selectable direction, speed divider and clear.

Parameters:
- ROW_BITS, 1440: bits per ROM row (banner width in pixels).
- ROWS, 38: number of banner rows displayed.
- ADDR_W, 6: ROM address width.
- ROM_BASE, 1: ROM address of the first displayed row.
- X_W, 11: width of pix_x and pix_y.
- ORIGIN_X, 0: left edge of the display window.
- ORIGIN_Y, 200: top edge of the display window.
- WIN_W, 640: window width in pixels. Must satisfy WIN_W <= ROW_BITS.
- STEP, 2: pixels moved per scroll step. Must satisfy 1 <= STEP < ROW_BITS.
- SCROLL_DIV, 2: frame_start pulses per scroll step (>= 1).
- CW, 11: column/offset width, equal to clog2(ROW_BITS).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- pix_x  in  X_W  current pixel column from the timing generator.
- pix_y  in  X_W  current pixel row from the timing generator.
- frame_start  in  1  one-cycle pulse per frame.
- scroll_en  in  1  enables scroll stepping.
- scroll_dir  in  1  0 = text moves left (offset increments); 1 = text moves right (offset decrements).
- scroll_clr  in  1  synchronous clear of offset and divider.
- rom_addr  out  ADDR_W  registered row address to the combinational ROM.
- rom_data  in  ROW_BITS  ROM row word; bit ROW_BITS-1 is column 0.
- pix_on  out  1  registered pixel flag.
- in_win_d  out  1  window flag, aligned with pix_on.
- scroll_offset  out  CW  current offset (status).

Behaviour:
- Reset (asynchronous, rst=1): rom_addr=0, pix_on=0, in_win_d=0, scroll_offset=0, divider=0, all internal pipeline registers 0. Reset asserted mid-frame or mid-step takes effect immediately; operation resumes on the first clk edge after release.
- Window: win = (ORIGIN_Y <= pix_y < ORIGIN_Y+ROWS) and (ORIGIN_X <= pix_x < ORIGIN_X+WIN_W).
- Stage 1 (edge N+1 for inputs at cycle N):
  - win_r <= win.
  - If win: rom_addr <= ROM_BASE + (pix_y - ORIGIN_Y).
  - col_r <= (pix_x - ORIGIN_X) + offset, minus ROW_BITS if the sum >= ROW_BITS. One conditional subtract suffices because WIN_W <= ROW_BITS.
  - If not win: rom_addr <= 0 and col_r <= 0.
- Stage 2 (edge N+2):
  - pix_on <= win_r & rom_data[ROW_BITS-1-col_r].
  - in_win_d <= win_r.
  - Fixed latency is 2 cycles; no stalls.
- rom_data is sampled in the cycle after rom_addr updates. The ROM is combinational.
- Scroll divider counts frame_start pulses while scroll_en=1; it holds when scroll_en=0. On a pulse with divider = SCROLL_DIV-1: divider -> 0 and a step occurs.
- Step, dir=0: offset -> offset+STEP, or offset+STEP-ROW_BITS if that is >= ROW_BITS.
- Step, dir=1: offset -> offset-STEP, or offset-STEP+ROW_BITS if offset < STEP.
- Offset changes only on frame_start, so there is no mid-frame tearing.
- scroll_clr=1: offset -> 0 and divider -> 0. It takes priority over a simultaneous step.
- scroll_dir changes take effect at the next step; the divider is not reset.
- Width rules: all subtractions are performed at X_W+1 bits. The ROM row index is truncated to ADDR_W.

Test Plan:
- Reset: assert rst asynchronously mid-line with pix_on=1 -> pix_on, rom_addr, scroll_offset and in_win_d read 0 before the next clk edge. Release rst -> first valid pix_on appears 2 cycles after the first in-window pixel.
- Latency and bit order: stub ROM returns only the MSB set at address 1; drive pix_x=0, pix_y=200 at cycle N -> rom_addr=1 at N+1, pix_on=1 and in_win_d=1 at N+2. Drive pix_x=1 -> pix_on=0.
- Window edges: pix_y=199, pix_y=238, or pix_x=640 -> pix_on=0, in_win_d=0, rom_addr=0. pix_y=237 -> rom_addr=38.
- Scroll left: scroll_en=1, dir=0, 4 frame_start pulses -> scroll_offset=4. Then pix_x=0 selects rom_data bit 1435.
- Wrap: offset=1438 with dir=0 -> next step gives 0. Offset=0 with dir=1 -> next step gives 1438. Offset=1000 with pix_x=500 -> column 60 (bit 1379).
- Priority: scroll_clr=1 in the same cycle as a stepping frame_start -> offset=0, divider=0. With scroll_en=0, 10 pulses -> offset unchanged.

Source files
------------

// File: rtl/banner_rom_scroller.sv
// Banner ROM pixel reader with frame-synchronous wrap-around scrolling.
// Two-stage pipeline: window/address/column, then ROM bit select.
module banner_rom_scroller #(
    parameter int ROW_BITS   = 1440,
    parameter int ROWS       = 38,
    parameter int ADDR_W     = 6,
    parameter int ROM_BASE   = 1,
    parameter int X_W        = 11,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 200,
    parameter int WIN_W      = 640,
    parameter int STEP       = 2,
    parameter int SCROLL_DIV = 2,
    parameter int CW         = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [X_W-1:0]      pix_x,
    input  logic [X_W-1:0]      pix_y,
    input  logic                frame_start,
    input  logic                scroll_en,
    input  logic                scroll_dir,
    input  logic                scroll_clr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [ROW_BITS-1:0] rom_data,
    output logic                pix_on,
    output logic                in_win_d,
    output logic [CW-1:0]       scroll_offset
);

    localparam int SW  = X_W + 1;
    localparam int CW1 = CW + 1;
    localparam int CSW = ((SW > CW) ? SW : CW) + 1;
    localparam int DW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [SW-1:0]     px;
    logic [SW-1:0]     py;
    logic [SW-1:0]     rel_x;
    logic [SW-1:0]     rel_y;
    logic              x_ok;
    logic              y_ok;
    logic              win;
    logic [CSW-1:0]    col_sum;
    logic [CW-1:0]     col_nx;
    logic [ADDR_W-1:0] addr_nx;

    logic              win_r;
    logic [CW-1:0]     col_r;
    logic [CW-1:0]     bit_idx;

    logic [DW-1:0]     div;
    logic              div_last;
    logic              pulse;
    logic              step;
    logic [CW1-1:0]    up_sum;
    logic [CW-1:0]     up_nx;
    logic [CW-1:0]     dn_nx;
    logic [CW-1:0]     step_nx;

    // Window test and relative coordinates, all at X_W+1 bits.
    always_comb begin
        px    = {1'b0, pix_x};
        py    = {1'b0, pix_y};
        rel_x = px - SW'(ORIGIN_X);
        rel_y = py - SW'(ORIGIN_Y);
        x_ok  = (px >= SW'(ORIGIN_X)) &&
                (px <  SW'(ORIGIN_X + WIN_W));
        y_ok  = (py >= SW'(ORIGIN_Y)) &&
                (py <  SW'(ORIGIN_Y + ROWS));
        win   = x_ok & y_ok;
    end

    // Scrolled column with a single conditional wrap.
    always_comb begin
        col_sum = CSW'(rel_x) + CSW'(scroll_offset);
        if (col_sum >= CSW'(ROW_BITS)) begin
            col_nx = CW'(col_sum - CSW'(ROW_BITS));
        end else begin
            col_nx = CW'(col_sum);
        end
        addr_nx = ADDR_W'(SW'(ROM_BASE) + rel_y);
    end

    // Stage 1: register window flag, ROM row address and column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_r    <= 1'b0;
            rom_addr <= '0;
            col_r    <= '0;
        end else begin
            win_r <= win;
            if (win) begin
                rom_addr <= addr_nx;
                col_r    <= col_nx;
            end else begin
                rom_addr <= '0;
                col_r    <= '0;
            end
        end
    end

    // Column 0 sits in the MSB of the ROM word.
    always_comb begin
        bit_idx = CW'(ROW_BITS - 1) - col_r;
    end

    // Stage 2: pick the bit from the ROM row addressed last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_on   <= 1'b0;
            in_win_d <= 1'b0;
        end else begin
            pix_on   <= win_r & rom_data[bit_idx];
            in_win_d <= win_r;
        end
    end

    // Next offset candidates for either direction, wrapped into range.
    always_comb begin
        up_sum = {1'b0, scroll_offset} + CW1'(STEP);
        if (up_sum >= CW1'(ROW_BITS)) begin
            up_nx = CW'(up_sum - CW1'(ROW_BITS));
        end else begin
            up_nx = CW'(up_sum);
        end
        if (scroll_offset < CW'(STEP)) begin
            dn_nx = CW'({1'b0, scroll_offset} +
                        CW1'(ROW_BITS - STEP));
        end else begin
            dn_nx = scroll_offset - CW'(STEP);
        end
        step_nx  = scroll_dir ? dn_nx : up_nx;
        div_last = (div == DW'(SCROLL_DIV - 1));
        pulse    = frame_start & scroll_en;
        step     = pulse & div_last;
    end

    // Divider and offset; clear wins over a coincident step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div           <= '0;
            scroll_offset <= '0;
        end else if (scroll_clr) begin
            div           <= '0;
            scroll_offset <= '0;
        end else if (step) begin
            div           <= '0;
            scroll_offset <= step_nx;
        end else if (pulse) begin
            div           <= div + DW'(1);
        end
    end

endmodule

// File: tb/tb_banner_rom_scroller.sv
// Self-checking bench for banner_rom_scroller.
// Reference: modular-arithmetic offset model and array ROM lookup.
module tb_banner_rom_scroller;

    localparam int ROW_BITS   = 1440;
    localparam int ROWS       = 38;
    localparam int ADDR_W     = 6;
    localparam int ROM_BASE   = 1;
    localparam int X_W        = 11;
    localparam int ORIGIN_X   = 0;
    localparam int ORIGIN_Y   = 200;
    localparam int WIN_W      = 640;
    localparam int STEP       = 2;
    localparam int SCROLL_DIV = 2;
    localparam int CW         = 11;
    localparam int NPIX       = 300;

    logic                clk = 1'b0;
    logic                rst;
    logic [X_W-1:0]      pix_x;
    logic [X_W-1:0]      pix_y;
    logic                frame_start;
    logic                scroll_en;
    logic                scroll_dir;
    logic                scroll_clr;
    logic [ADDR_W-1:0]   rom_addr;
    logic [ROW_BITS-1:0] rom_data;
    logic                pix_on;
    logic                in_win_d;
    logic [CW-1:0]       scroll_offset;

    logic [ROW_BITS-1:0] rom_mem [64];

    int total = 0;
    int bad   = 0;
    int m_off = 0;
    int m_div = 0;

    banner_rom_scroller #(
        .ROW_BITS(ROW_BITS), .ROWS(ROWS), .ADDR_W(ADDR_W),
        .ROM_BASE(ROM_BASE), .X_W(X_W), .ORIGIN_X(ORIGIN_X),
        .ORIGIN_Y(ORIGIN_Y), .WIN_W(WIN_W), .STEP(STEP),
        .SCROLL_DIV(SCROLL_DIV), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .scroll_en(scroll_en),
        .scroll_dir(scroll_dir), .scroll_clr(scroll_clr),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_on(pix_on), .in_win_d(in_win_d),
        .scroll_offset(scroll_offset)
    );

    assign rom_data = rom_mem[rom_addr];

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic rom_fill(input logic v);
        for (int a = 0; a < 64; a++)
            rom_mem[a] = v ? '1 : '0;
    endtask

    task automatic rom_onehot(input int a, input int b);
        rom_fill(1'b0);
        rom_mem[a][b] = 1'b1;
    endtask

    task automatic rom_random;
        for (int a = 0; a < 64; a++)
            for (int w = 0; w < ROW_BITS / 32; w++)
                rom_mem[a][w*32 +: 32] = $urandom;
    endtask

    function automatic logic exp_win(input int x, input int y);
        return (y >= ORIGIN_Y) && (y < ORIGIN_Y + ROWS) &&
               (x >= ORIGIN_X) && (x < ORIGIN_X + WIN_W);
    endfunction

    function automatic logic exp_pix(input int x, input int y,
                                     input int off);
        int col;
        int row;
        if (!exp_win(x, y)) return 1'b0;
        col = (x - ORIGIN_X + off) % ROW_BITS;
        row = ROM_BASE + y - ORIGIN_Y;
        return rom_mem[row][ROW_BITS - 1 - col];
    endfunction

    task automatic drive(input int x, input int y);
        pix_x = X_W'(x);
        pix_y = X_W'(y);
    endtask

    // One cycle of scroll control plus model update.
    task automatic pulse(input logic fs, input logic en,
                         input logic dir, input logic clr);
        frame_start = fs;
        scroll_en   = en;
        scroll_dir  = dir;
        scroll_clr  = clr;
        cyc;
        frame_start = 1'b0;
        scroll_clr  = 1'b0;
        if (clr) begin
            m_off = 0;
            m_div = 0;
        end else if (fs && en) begin
            m_div++;
            if (m_div == SCROLL_DIV) begin
                m_div = 0;
                if (dir) m_off = (m_off - STEP + ROW_BITS) % ROW_BITS;
                else     m_off = (m_off + STEP) % ROW_BITS;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        frame_start = 0; scroll_en = 0;
        scroll_dir = 0; scroll_clr = 0;
        drive(0, 0);
        rom_fill(1'b0);
        #12;
        total++;
        if (pix_on !== 1'b0 || in_win_d !== 1'b0 ||
            rom_addr !== '0 || scroll_offset !== '0) begin
            bad++;
            $display("FAIL reset got=%b/%b/%0d/%0d exp=0/0/0/0",
                     pix_on, in_win_d, rom_addr, scroll_offset);
        end
        rst = 1'b0;
        cyc;
    endtask

    task automatic test_latency;
        pulse(0, 0, 0, 1);
        rom_onehot(1, ROW_BITS - 1);
        drive(0, 200);
        cyc;
        total++;
        if (rom_addr !== 6'd1) begin
            bad++;
            $display("FAIL lat_addr got=%0d exp=1", rom_addr);
        end
        cyc;
        total++;
        if (pix_on !== 1'b1 || in_win_d !== 1'b1) begin
            bad++;
            $display("FAIL lat_pix got=%b/%b exp=1/1",
                     pix_on, in_win_d);
        end
        drive(1, 200);
        cyc;
        cyc;
        total++;
        if (pix_on !== 1'b0) begin
            bad++;
            $display("FAIL lat_col1 got=%b exp=0", pix_on);
        end
    endtask

    task automatic test_window_edges;
        int xs [4] = '{0, 0, 640, 639};
        int ys [4] = '{199, 238, 200, 237};
        int ea [4] = '{0, 0, 0, 38};
        logic ew;
        rom_fill(1'b1);
        for (int i = 0; i < 4; i++) begin
            ew = exp_win(xs[i], ys[i]);
            drive(xs[i], ys[i]);
            cyc;
            total++;
            if (rom_addr !== ADDR_W'(ea[i])) begin
                bad++;
                $display("FAIL edge_addr%0d got=%0d exp=%0d",
                         i, rom_addr, ea[i]);
            end
            cyc;
            total++;
            if (pix_on !== ew || in_win_d !== ew) begin
                bad++;
                $display("FAIL edge_win%0d got=%b/%b exp=%b",
                         i, pix_on, in_win_d, ew);
            end
        end
    endtask

    task automatic test_scroll_left;
        pulse(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) pulse(1, 1, 0, 0);
        total++;
        if (scroll_offset !== 11'd4 || m_off != 4) begin
            bad++;
            $display("FAIL left_off got=%0d exp=4", scroll_offset);
        end
        rom_onehot(1, 1435);
        drive(0, 200);
        cyc;
        cyc;
        total++;
        if (pix_on !== exp_pix(0, 200, m_off)) begin
            bad++;
            $display("FAIL left_bit got=%b exp=1", pix_on);
        end
    endtask

    task automatic test_wrap;
        pulse(0, 0, 0, 1);
        pulse(1, 1, 1, 0);
        pulse(1, 1, 1, 0);
        total++;
        if (scroll_offset !== 11'd1438) begin
            bad++;
            $display("FAIL wrap_dn got=%0d exp=1438", scroll_offset);
        end
        pulse(1, 1, 0, 0);
        pulse(1, 1, 0, 0);
        total++;
        if (scroll_offset !== 11'd0) begin
            bad++;
            $display("FAIL wrap_up got=%0d exp=0", scroll_offset);
        end
        for (int i = 0; i < 440; i++) pulse(1, 1, 1, 0);
        total++;
        if (scroll_offset !== 11'd1000 || m_off != 1000) begin
            bad++;
            $display("FAIL wrap_1000 got=%0d exp=1000",
                     scroll_offset);
        end
        rom_onehot(1, 1379);
        drive(500, 200);
        cyc;
        cyc;
        total++;
        if (pix_on !== 1'b1) begin
            bad++;
            $display("FAIL wrap_col60 got=%b exp=1", pix_on);
        end
        drive(501, 200);
        cyc;
        cyc;
        total++;
        if (pix_on !== 1'b0) begin
            bad++;
            $display("FAIL wrap_col61 got=%b exp=0", pix_on);
        end
    endtask

    task automatic test_priority;
        pulse(0, 0, 0, 1);
        pulse(1, 1, 0, 0);
        pulse(1, 1, 0, 0);
        pulse(1, 1, 0, 0);
        pulse(1, 1, 0, 1);
        total++;
        if (scroll_offset !== 11'd0) begin
            bad++;
            $display("FAIL prio_clr got=%0d exp=0", scroll_offset);
        end
        pulse(1, 1, 0, 0);
        total++;
        if (scroll_offset !== 11'd0) begin
            bad++;
            $display("FAIL prio_div got=%0d exp=0", scroll_offset);
        end
        pulse(1, 1, 0, 0);
        total++;
        if (scroll_offset !== 11'd2) begin
            bad++;
            $display("FAIL prio_step got=%0d exp=2", scroll_offset);
        end
        for (int i = 0; i < 10; i++) pulse(1, 0, 0, 0);
        total++;
        if (scroll_offset !== 11'd2) begin
            bad++;
            $display("FAIL prio_hold got=%0d exp=2", scroll_offset);
        end
    endtask

    task automatic test_random_scroll;
        logic fs, en, dir, clr;
        for (int i = 0; i < 300; i++) begin
            fs  = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 3) != 0);
            dir = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 19) == 0);
            pulse(fs, en, dir, clr);
            total++;
            if (scroll_offset !== CW'(m_off)) begin
                bad++;
                $display("FAIL rscroll%0d got=%0d exp=%0d",
                         i, scroll_offset, m_off);
            end
        end
    endtask

    task automatic test_random_pixels;
        logic ep [NPIX];
        logic ew [NPIX];
        int x;
        int y;
        rom_random;
        for (int i = 0; i < 37; i++) pulse(1, 1, 0, 0);
        for (int i = 0; i < NPIX; i++) begin
            x = $urandom_range(0, 700);
            y = $urandom_range(190, 245);
            ep[i] = exp_pix(x, y, m_off);
            ew[i] = exp_win(x, y);
            drive(x, y);
            cyc;
            if (i >= 1) begin
                total++;
                if (pix_on !== ep[i-1] || in_win_d !== ew[i-1]) begin
                    bad++;
                    $display("FAIL rpix%0d got=%b/%b exp=%b/%b",
                             i - 1, pix_on, in_win_d,
                             ep[i-1], ew[i-1]);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        pulse(0, 0, 0, 1);
        pulse(1, 1, 0, 0);
        pulse(1, 1, 0, 0);
        rom_fill(1'b1);
        drive(0, 200);
        cyc;
        cyc;
        total++;
        if (pix_on !== 1'b1 || scroll_offset !== 11'd2) begin
            bad++;
            $display("FAIL ar_pre got=%b/%0d exp=1/2",
                     pix_on, scroll_offset);
        end
        #2 rst = 1'b1;
        #1;
        m_off = 0;
        m_div = 0;
        total++;
        if (pix_on !== 1'b0 || in_win_d !== 1'b0 ||
            rom_addr !== '0 || scroll_offset !== '0) begin
            bad++;
            $display("FAIL ar_mid got=%b/%b/%0d/%0d exp=0/0/0/0",
                     pix_on, in_win_d, rom_addr, scroll_offset);
        end
        drive(0, 238);
        #2 rst = 1'b0;
        cyc;
        drive(0, 200);
        cyc;
        total++;
        if (pix_on !== 1'b0) begin
            bad++;
            $display("FAIL ar_early got=%b exp=0", pix_on);
        end
        cyc;
        total++;
        if (pix_on !== 1'b1 || in_win_d !== 1'b1) begin
            bad++;
            $display("FAIL ar_first got=%b/%b exp=1/1",
                     pix_on, in_win_d);
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_window_edges;
        test_scroll_left;
        test_wrap;
        test_priority;
        test_random_scroll;
        test_random_pixels;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
